// File: rtl/step_accumulator.sv
// Step-indexed signed multiply-accumulate that follows the 38-step sequencer.
// Optional macro STEP_ACC_RELU_EN clamps a negative final pass sum to zero.
//
//   state | meaning
//   IDLE  | waiting for step 0 with step_en high
//   ACCUM | pass in progress, expecting step exp_q next
module step_accumulator #(
  parameter int NUM_STEPS = 38,
  parameter int STEP_W    = 9,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_en,
  input  logic [STEP_W-1:0]        step_in,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] w_in,
  input  logic signed [ACC_W-1:0]  threshold,
  output logic signed [ACC_W-1:0]  result,
  output logic                     result_valid,
  output logic                     fire,
  output logic                     busy,
  output logic                     aborted,
  output logic [7:0]               pass_count
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [ACC_W-1:0]  MAX_POS   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]  MAX_NEG   = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                   state_q;
  logic [ACC_W-1:0]         acc_q;
  logic                     sat_q;
  logic [STEP_W-1:0]        exp_q;
  logic signed [ACC_W-1:0]  result_q;
  logic                     result_valid_q;
  logic                     fire_q;
  logic                     busy_q;
  logic                     aborted_q;
  logic [7:0]               pass_count_q;

  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]           prod_ext;
  logic [ACC_W:0]             sum_wide;
  logic                       ovf_d;
  logic [ACC_W-1:0]           sum_d;
  logic signed [ACC_W-1:0]    final_d;

  always_comb begin
    prod     = x_in * w_in;
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    sum_wide = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
    ovf_d    = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    // Once a pass has hit a rail it stays there until the pass ends.
    if (sat_q)
      sum_d = acc_q;
    else if (ovf_d)
      sum_d = sum_wide[ACC_W] ? MAX_NEG : MAX_POS;
    else
      sum_d = sum_wide[ACC_W-1:0];
`ifdef STEP_ACC_RELU_EN
    final_d = sum_d[ACC_W-1] ? '0 : sum_d;
`else
    final_d = sum_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      sat_q          <= 1'b0;
      exp_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      fire_q         <= 1'b0;
      busy_q         <= 1'b0;
      aborted_q      <= 1'b0;
      pass_count_q   <= '0;
    end else begin
      result_valid_q <= 1'b0;
      aborted_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          // acc_q is always zero here, so sum_d is sat(p).
          if (step_en && step_in == '0) begin
            acc_q   <= sum_d;
            sat_q   <= ovf_d;
            exp_q   <= STEP_W'(1);
            busy_q  <= 1'b1;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (!step_en || step_in != exp_q) begin
            aborted_q <= 1'b1;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            exp_q     <= '0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (exp_q == LAST_STEP) begin
            result_q       <= final_d;
            fire_q         <= final_d > threshold;
            result_valid_q <= 1'b1;
            pass_count_q   <= pass_count_q + 8'd1;
            acc_q          <= '0;
            sat_q          <= 1'b0;
            exp_q          <= '0;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end else begin
            acc_q <= sum_d;
            sat_q <= sat_q | ovf_d;
            exp_q <= exp_q + STEP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign fire         = fire_q;
  assign busy         = busy_q;
  assign aborted      = aborted_q;
  assign pass_count   = pass_count_q;

endmodule

// File: tb/tb_step_accumulator.sv
// Scoreboard bench for step_accumulator; honours STEP_ACC_RELU_EN like the RTL.
module tb_step_accumulator;

  localparam int NUM_STEPS = 38;
  localparam int ACC_MAX   = 524287;
  localparam int ACC_MIN   = -524288;

  typedef struct {
    logic signed [19:0] res;
    logic               fire;
    logic [7:0]         pc;
    int                 cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               step_en;
  logic [8:0]         step_in;
  logic signed [7:0]  x_in;
  logic signed [7:0]  w_in;
  logic signed [19:0] threshold;
  logic signed [19:0] result;
  logic               result_valid;
  logic               fire;
  logic               busy;
  logic               aborted;
  logic [7:0]         pass_count;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   exp_abort = 0;
  int   exp_pc = 0;
  logic signed [19:0] last_res = '0;
  logic last_fire = 1'b0;
  exp_t sb[$];

  step_accumulator dut (
    .clk(clk), .rst(rst), .step_en(step_en), .step_in(step_in),
    .x_in(x_in), .w_in(w_in), .threshold(threshold),
    .result(result), .result_valid(result_valid), .fire(fire),
    .busy(busy), .aborted(aborted), .pass_count(pass_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    if (result_valid === 1'b1) begin
      n_cmp++;
      if (aborted !== 1'b0) begin
        n_err++;
        $display("FAIL pulse_overlap: aborted=%b required 0 with result_valid", aborted);
      end
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: result_valid=1 required 0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res || fire !== e.fire || pass_count !== e.pc || cyc != e.cyc) begin
          n_err++;
          $display("FAIL pass_result: got res=%0d fire=%b pc=%0d cyc=%0d required res=%0d fire=%b pc=%0d cyc=%0d",
                   result, fire, pass_count, cyc, e.res, e.fire, e.pc, e.cyc);
        end
      end
    end
    if (aborted === 1'b1) begin
      n_cmp++;
      if (exp_abort == 0) begin
        n_err++;
        $display("FAIL unexpected_abort: aborted=1 required 0 at cycle %0d", cyc);
      end else begin
        exp_abort--;
      end
    end
  end

  function automatic exp_t model(input int x, input int w, input int thr);
    exp_t e;
    int acc = 0;
    int s;
    bit sat = 0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (!sat) begin
        s = acc + x * w;
        if (s > ACC_MAX) begin acc = ACC_MAX; sat = 1; end
        else if (s < ACC_MIN) begin acc = ACC_MIN; sat = 1; end
        else acc = s;
      end
    end
`ifdef STEP_ACC_RELU_EN
    if (acc < 0) acc = 0;
`endif
    e.res  = acc[19:0];
    e.fire = acc > thr;
    e.pc   = '0;
    e.cyc  = 0;
    return e;
  endfunction

  task automatic drive(input logic en, input int step, input int x, input int w);
    @(negedge clk);
    step_en = en;
    step_in = step[8:0];
    x_in    = x[7:0];
    w_in    = w[7:0];
  endtask

  task automatic full_pass(input int x, input int w, input int thr);
    exp_t e;
    e = model(x, w, thr);
    for (int i = 0; i < NUM_STEPS; i++) begin
      drive(1'b1, i, x, w);
      if (i == 0) threshold = thr[19:0];
    end
    exp_pc    = (exp_pc + 1) % 256;
    e.pc      = exp_pc[7:0];
    e.cyc     = cyc + 1;
    last_res  = e.res;
    last_fire = e.fire;
    sb.push_back(e);
  endtask

  task automatic check_idle_outputs(input string name);
    n_cmp++;
    if (result !== last_res || fire !== last_fire || busy !== 1'b0 ||
        result_valid !== 1'b0 || aborted !== 1'b0 || pass_count !== exp_pc[7:0]) begin
      n_err++;
      $display("FAIL %s: res=%0d fire=%b busy=%b rv=%b ab=%b pc=%0d required res=%0d fire=%b busy=0 rv=0 ab=0 pc=%0d",
               name, result, fire, busy, result_valid, aborted, pass_count, last_res, last_fire, exp_pc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step_en = 1'b0; step_in = '0; x_in = '0; w_in = '0; threshold = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_pass();
    full_pass(1, 1, 37);
    @(posedge clk); #1;
    n_cmp++;
    if (result_valid !== 1'b1 || result !== 20'sd38 || fire !== 1'b1) begin
      n_err++;
      $display("FAIL full_pass_latency: rv=%b res=%0d fire=%b required rv=1 res=38 fire=1", result_valid, result, fire);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL valid_one_cycle: rv=%b required 0", result_valid);
    end
    drive(1'b0, 0, 0, 0);
  endtask

  task automatic test_threshold_boundary();
    full_pass(1, 1, 38);
    drive(1'b0, 0, 0, 0);
    @(posedge clk); #1;
    n_cmp++;
    if (fire !== 1'b0 || result !== 20'sd38) begin
      n_err++;
      $display("FAIL fire_equal_threshold: fire=%b res=%0d required fire=0 res=38", fire, result);
    end
  endtask

  task automatic test_saturation();
    full_pass(127, 127, 0);
    drive(1'b0, 0, 0, 0);
    @(posedge clk); #1;
    n_cmp++;
    if (result !== 20'sd524287) begin
      n_err++;
      $display("FAIL pos_sat: res=%0d required 524287", result);
    end
    full_pass(-128, 127, 0);
    drive(1'b0, 0, 0, 0);
    @(posedge clk); #1;
    n_cmp++;
`ifdef STEP_ACC_RELU_EN
    if (result !== 20'sd0 || fire !== 1'b0) begin
      n_err++;
      $display("FAIL neg_sat_relu: res=%0d fire=%b required res=0 fire=0", result, fire);
    end
`else
    if (result !== -20'sd524288 || fire !== 1'b0) begin
      n_err++;
      $display("FAIL neg_sat: res=%0d fire=%b required res=-524288 fire=0", result, fire);
    end
`endif
  endtask

  task automatic test_idle_ignore();
    repeat (3) drive(1'b1, 5, 1, 1);
    @(posedge clk); #1;
    check_idle_outputs("idle_ignore_nonzero");
    drive(1'b0, 0, 0, 0);
  endtask

  task automatic test_abort_enable_drop();
    for (int i = 0; i <= 20; i++) drive(1'b1, i, 1, 1);
    exp_abort++;
    drive(1'b0, 21, 1, 1);
    @(posedge clk); #1;
    n_cmp++;
    if (aborted !== 1'b1 || busy !== 1'b0 || result !== last_res || pass_count !== exp_pc[7:0]) begin
      n_err++;
      $display("FAIL abort_drop: ab=%b busy=%b res=%0d pc=%0d required ab=1 busy=0 res=%0d pc=%0d",
               aborted, busy, result, pass_count, last_res, exp_pc);
    end
    @(posedge clk); #1;
    check_idle_outputs("abort_drop_after");
    full_pass(1, 1, 37);
    drive(1'b0, 0, 0, 0);
  endtask

  task automatic test_step_skip();
    for (int i = 0; i <= 5; i++) drive(1'b1, i, 2, 3);
    exp_abort++;
    drive(1'b1, 7, 2, 3);
    @(posedge clk); #1;
    n_cmp++;
    if (aborted !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL step_skip_abort: ab=%b busy=%b required ab=1 busy=0", aborted, busy);
    end
    for (int i = 8; i < NUM_STEPS; i++) drive(1'b1, i, 2, 3);
    @(posedge clk); #1;
    check_idle_outputs("step_skip_ignored");
    drive(1'b0, 0, 0, 0);
  endtask

  task automatic test_random_passes();
    for (int k = 0; k < 3; k++) begin
      int x, w, thr;
      x   = int'($urandom_range(255)) - 128;
      w   = int'($urandom_range(255)) - 128;
      thr = int'($urandom_range(200000)) - 100000;
      full_pass(x, w, thr);
      drive(1'b0, 0, 0, 0);
    end
  endtask

  task automatic test_reset_mid_pass();
    for (int i = 0; i <= 15; i++) drive(1'b1, i, 1, 1);
    @(negedge clk);
    rst = 1'b1; step_in = 9'd16;
    @(posedge clk); #1;
    exp_pc = 0; last_res = '0; last_fire = 1'b0;
    check_idle_outputs("reset_mid_pass");
    @(negedge clk);
    rst = 1'b0; step_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    full_pass(1, 1, 37);
    full_pass(1, 1, 37);
    drive(1'b0, 0, 0, 0);
    @(posedge clk); #1;
    n_cmp++;
    if (pass_count !== 8'd2 || result !== 20'sd38) begin
      n_err++;
      $display("FAIL back_to_back: pc=%0d res=%0d required pc=2 res=38", pass_count, result);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_threshold_boundary();
    test_saturation();
    test_idle_ignore();
    test_abort_enable_drop();
    test_step_skip();
    test_random_passes();
    test_reset_mid_pass();
    test_back_to_back();
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0 || exp_abort != 0) begin
      n_err++;
      $display("FAIL drain: pending results=%0d pending aborts=%0d required 0 and 0", sb.size(), exp_abort);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
